// File: rtl/pcie_dma_read_engine.sv
// Endpoint DMA read requester: one MRd TLP per command, CplD data written to a local buffer.
// Define DMA_RD_TIMEOUT_EN to enable the completion timeout (TIMEOUT_CYC cycles in WAIT).
module pcie_dma_read_engine #(
  parameter int unsigned BUF_AW      = 10,
  parameter int unsigned MAX_READ_DW = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic [15:0]       requester_id,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [63:0]       cmd_addr,
  input  logic [9:0]        cmd_len,
  input  logic [BUF_AW-1:0] cmd_buf_addr,
  output logic              done,
  output logic              error,
  output logic [63:0]       s_axis_tx_tdata,
  output logic [7:0]        s_axis_tx_tkeep,
  output logic              s_axis_tx_tlast,
  output logic              s_axis_tx_tvalid,
  output logic [3:0]        s_axis_tx_tuser,
  input  logic              s_axis_tx_tready,
  input  logic [63:0]       m_axis_rx_tdata,
  input  logic [7:0]        m_axis_rx_tkeep,
  input  logic              m_axis_rx_tlast,
  input  logic              m_axis_rx_tvalid,
  input  logic [21:0]       m_axis_rx_tuser,
  output logic              m_axis_rx_tready,
  output logic [1:0]        buf_we,
  output logic [BUF_AW-1:0] buf_waddr0,
  output logic [BUF_AW-1:0] buf_waddr1,
  output logic [31:0]       buf_wdata0,
  output logic [31:0]       buf_wdata1
);

  localparam logic [9:0] MaxLen  = 10'(MAX_READ_DW);
  localparam logic [7:0] FmtCplD = 8'h4A;
  localparam logic [7:0] FmtCpl  = 8'h0A;

  typedef enum logic [2:0] {StIdle, StTx0, StTx1, StWait, StDone} state_e;

  state_e            state_q;
  logic [7:0]        tag_q;
  logic [9:0]        rem_q;
  logic [BUF_AW-1:0] ptr_q;
  logic [63:0]       tx_beat1_q;
  logic [7:0]        tx_keep1_q;

  // RX parser: beat index saturates at 2 ("data-only beat").
  logic [1:0]        rx_beat_q;
  logic [7:0]        rx_fmt_q;
  logic [2:0]        rx_status_q;
  logic              rx_hit_q;
  logic              rx_fail_q;

`ifdef DMA_RD_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] to_cnt_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
`endif

  logic unused_in;
  assign unused_in = ^{m_axis_rx_tuser, cmd_addr[1:0]};

  assign s_axis_tx_tuser = 4'h0;

  // MRd header built from the live command inputs at accept time.
  logic        is_4dw;
  logic        len_bad;
  logic [31:0] dw0, dw1, addr_lo;
  logic [63:0] beat1;
  logic [7:0]  keep1;

  always_comb begin
    is_4dw  = |cmd_addr[63:32];
    len_bad = (cmd_len == 10'd0) || (cmd_len > MaxLen);
    dw0     = {(is_4dw ? 8'h20 : 8'h00), 14'h0, cmd_len};
    dw1     = {requester_id, tag_q, ((cmd_len == 10'd1) ? 4'h0 : 4'hF), 4'hF};
    addr_lo = {cmd_addr[31:2], 2'b00};
    beat1   = is_4dw ? {addr_lo, cmd_addr[63:32]} : {32'h0, addr_lo};
    keep1   = is_4dw ? 8'hFF : 8'h0F;
  end

  logic        rx_fire, in_wait, rx_b1, hit, good, fail_hdr, fail_ovf, fail_all;
  logic        lo_v, hi_v, data_en, tlp_end;
  logic [1:0]  n_dw, wr_n;
  logic [9:0]  rem_nxt;
  logic [31:0] d0, d1;

  always_comb begin
    rx_fire  = m_axis_rx_tvalid & m_axis_rx_tready;
    in_wait  = (state_q == StWait);
    rx_b1    = (rx_beat_q == 2'd1);
    // Tag/type are only known once DW2 (beat 1) arrives.
    hit      = in_wait & (rx_b1 ? ((m_axis_rx_tdata[15:8] == tag_q) &
                                   ((rx_fmt_q == FmtCplD) | (rx_fmt_q == FmtCpl)))
                                : ((rx_beat_q == 2'd2) & rx_hit_q));
    good     = (rx_fmt_q == FmtCplD) & (rx_status_q == 3'd0);
    fail_hdr = rx_b1 & hit & ~good;
    lo_v     = ~rx_b1 & (|m_axis_rx_tkeep[3:0]);
    hi_v     = |m_axis_rx_tkeep[7:4];
    data_en  = rx_fire & hit & good;
    n_dw     = data_en ? ({1'b0, lo_v} + {1'b0, hi_v}) : 2'd0;
    fail_ovf = ({8'h0, n_dw} > rem_q);
    wr_n     = fail_ovf ? rem_q[1:0] : n_dw;
    rem_nxt  = rem_q - {8'h0, wr_n};
    fail_all = (~rx_b1 & rx_fail_q) | fail_hdr | fail_ovf;
    d0       = lo_v ? m_axis_rx_tdata[31:0] : m_axis_rx_tdata[63:32];
    d1       = m_axis_rx_tdata[63:32];
    tlp_end  = rx_fire & hit & m_axis_rx_tlast;
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q          <= StIdle;
      tag_q            <= 8'h0;
      rem_q            <= 10'h0;
      ptr_q            <= '0;
      tx_beat1_q       <= 64'h0;
      tx_keep1_q       <= 8'h0;
      rx_beat_q        <= 2'd0;
      rx_fmt_q         <= 8'h0;
      rx_status_q      <= 3'd0;
      rx_hit_q         <= 1'b0;
      rx_fail_q        <= 1'b0;
      cmd_ready        <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      s_axis_tx_tdata  <= 64'h0;
      s_axis_tx_tkeep  <= 8'h0;
      s_axis_tx_tlast  <= 1'b0;
      s_axis_tx_tvalid <= 1'b0;
      m_axis_rx_tready <= 1'b0;
      buf_we           <= 2'b00;
      buf_waddr0       <= '0;
      buf_waddr1       <= '0;
      buf_wdata0       <= 32'h0;
      buf_wdata1       <= 32'h0;
`ifdef DMA_RD_TIMEOUT_EN
      to_cnt_q         <= '0;
`endif
    end else begin
      m_axis_rx_tready <= 1'b1;
      done             <= 1'b0;
      buf_we           <= 2'b00;

      if (rx_fire) begin
        if (m_axis_rx_tlast)          rx_beat_q <= 2'd0;
        else if (rx_beat_q != 2'd2)   rx_beat_q <= rx_beat_q + 2'd1;
        if (rx_beat_q == 2'd0) begin
          rx_fmt_q    <= m_axis_rx_tdata[31:24];
          rx_status_q <= m_axis_rx_tdata[47:45];
        end
        if (rx_b1) rx_hit_q  <= hit;
        if (hit)   rx_fail_q <= fail_all;
      end

      // Excess dwords beyond the remaining count are dropped by clamping wr_n.
      if (data_en) begin
        buf_we     <= {wr_n == 2'd2, wr_n != 2'd0};
        buf_waddr0 <= ptr_q;
        buf_waddr1 <= ptr_q + BUF_AW'(1);
        buf_wdata0 <= d0;
        buf_wdata1 <= d1;
        rem_q      <= rem_nxt;
        ptr_q      <= ptr_q + BUF_AW'(wr_n);
      end

      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (len_bad) begin
              state_q <= StDone;
              done    <= 1'b1;
              error   <= 1'b1;
            end else begin
              rem_q            <= cmd_len;
              ptr_q            <= cmd_buf_addr;
              tx_beat1_q       <= beat1;
              tx_keep1_q       <= keep1;
              s_axis_tx_tdata  <= {dw1, dw0};
              s_axis_tx_tkeep  <= 8'hFF;
              s_axis_tx_tlast  <= 1'b0;
              s_axis_tx_tvalid <= 1'b1;
              state_q          <= StTx0;
            end
          end
        end
        StTx0: begin
          if (s_axis_tx_tready) begin
            s_axis_tx_tdata <= tx_beat1_q;
            s_axis_tx_tkeep <= tx_keep1_q;
            s_axis_tx_tlast <= 1'b1;
            state_q         <= StTx1;
          end
        end
        StTx1: begin
          if (s_axis_tx_tready) begin
            s_axis_tx_tdata  <= 64'h0;
            s_axis_tx_tkeep  <= 8'h0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tvalid <= 1'b0;
            state_q          <= StWait;
`ifdef DMA_RD_TIMEOUT_EN
            to_cnt_q         <= '0;
`endif
          end
        end
        StWait: begin
          // A matching TLP is judged as a whole at its last beat.
          if (tlp_end && (fail_all || rem_nxt == 10'd0)) begin
            state_q <= StDone;
            done    <= 1'b1;
            error   <= fail_all;
          end
`ifdef DMA_RD_TIMEOUT_EN
          else if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
            state_q <= StDone;
            done    <= 1'b1;
            error   <= 1'b1;
          end else begin
            to_cnt_q <= data_en ? '0 : to_cnt_q + ToW'(1);
          end
`endif
        end
        StDone: begin
          tag_q     <= tag_q + 8'h1;
          error     <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
